tdnn_layer_engine: RTL and testbench



---
 rtl/tdnn_layer_engine.sv | 203 ++++++++++++++++++++
 tb/tb_tdnn_layer_engine.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdnn_layer_engine.sv
// tdnn_layer_engine: time-multiplexed fully-connected TDNN layer.
// One MAC computes the neurons one after another. Weights and biases
// stream from an external synchronous memory with one cycle of read latency.
// A four-mode activation stage and a bank select pick the temperature state.
// Optional macro TDNN_LAYER_SAT_STATS_EN adds the sat_count output, which
// counts neurons whose rounded sum overflowed DATA_WIDTH.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE. out_valid, once high, holds until
// out_ready is sampled high, and out_vector stays stable over that interval.
module tdnn_layer_engine #(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int FRAC_BITS    = 15,
    parameter int ACC_WIDTH    = 40,
    parameter int IN_DIM       = 18,
    parameter int OUT_DIM      = 32,
    parameter int N_BANKS      = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] HT_LIMIT = DATA_WIDTH'(16'h4000)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH*IN_DIM-1:0]       in_vector,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [((N_BANKS > 1) ? $clog2(N_BANKS) : 1)-1:0] weight_bank_sel,
    input  logic [1:0]                         act_mode,
    output logic [ADDR_WIDTH-1:0]              weight_addr,
    output logic                               weight_rd_en,
    input  logic [WEIGHT_WIDTH-1:0]            weight_data,
    output logic [DATA_WIDTH*OUT_DIM-1:0]      out_vector,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy
`ifdef TDNN_LAYER_SAT_STATS_EN
    ,
    output logic [15:0]                        sat_count
`endif
);

    localparam int K_W = (IN_DIM + 1 > 1) ? $clog2(IN_DIM + 1) : 1;
    localparam int N_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(IN_DIM);
    localparam logic [N_W-1:0] N_LAST = N_W'(OUT_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] BANK_STRIDE = ADDR_WIDTH'(OUT_DIM * (IN_DIM + 1));
    localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

    // Rounding constant 2^(FRAC_BITS-1) and DATA_WIDTH range in ACC_WIDTH.
    localparam logic signed [ACC_WIDTH-1:0] RND =
        {{(ACC_WIDTH-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] MAXV =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MINV =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        ACT   = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t                          state_q, state_d;
    logic [DATA_WIDTH*IN_DIM-1:0]    x_q;
    logic [1:0]                      act_q;
    logic [ADDR_WIDTH-1:0]           addr_q;
    logic [K_W-1:0]                  k_q;
    logic [N_W-1:0]                  n_q;
    logic                            rd_vld_q;
    logic [K_W-1:0]                  rd_k_q;
    logic signed [ACC_WIDTH-1:0]     acc_q;
    logic [DATA_WIDTH*OUT_DIM-1:0]   out_vec_q;
    logic                            out_valid_q;

    logic signed [DATA_WIDTH-1:0]    x_k;
    logic signed [WEIGHT_WIDTH-1:0]  w_s;
    logic signed [PW-1:0]            prod;
    logic signed [ACC_WIDTH-1:0]     term;
    logic signed [ACC_WIDTH-1:0]     r_full;
    logic signed [DATA_WIDTH-1:0]    r_sat;
    logic                            sat_flag;
    logic signed [DATA_WIDTH-1:0]    ht_pos;
    logic signed [DATA_WIDTH-1:0]    ht_neg;
    logic signed [DATA_WIDTH-1:0]    act_val;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; OUT leaves only once out_valid has actually been seen.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ISSUE;
            ISSUE:   if (k_q == K_LAST) state_d = DRAIN;
            DRAIN:   state_d = ACT;
            ACT:     state_d = (n_q == N_LAST) ? OUT : ISSUE;
            OUT:     if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready     = (state_q == IDLE);
    assign weight_rd_en = (state_q == ISSUE);
    assign busy         = (state_q != IDLE);
    assign weight_addr  = addr_q;
    assign out_vector   = out_vec_q;
    assign out_valid    = out_valid_q;

    // MAC term: data word k times weight, or the bias aligned to the product scale.
    always_comb begin
        x_k  = '0;
        w_s  = $signed(weight_data);
        if (rd_k_q != K_LAST) x_k = $signed(x_q[rd_k_q*DATA_WIDTH +: DATA_WIDTH]);
        prod = x_k * w_s;
        if (rd_k_q == K_LAST)
            term = {{(ACC_WIDTH-WEIGHT_WIDTH-FRAC_BITS){w_s[WEIGHT_WIDTH-1]}}, w_s,
                    {FRAC_BITS{1'b0}}};
        else
            term = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    end

    // Round half up, saturate to DATA_WIDTH, then apply the captured activation.
    always_comb begin
        r_full   = (acc_q + RND) >>> FRAC_BITS;
        sat_flag = (r_full > MAXV) || (r_full < MINV);
        if (r_full > MAXV)      r_sat = MAXV[DATA_WIDTH-1:0];
        else if (r_full < MINV) r_sat = MINV[DATA_WIDTH-1:0];
        else                    r_sat = r_full[DATA_WIDTH-1:0];
        ht_pos  = $signed(HT_LIMIT);
        ht_neg  = -ht_pos;
        act_val = r_sat;
        case (act_q)
            2'b01:   if (r_sat < 0) act_val = '0;
            2'b10:   if (r_sat < 0) act_val = r_sat >>> 3;
            2'b11: begin
                if (r_sat > ht_pos)      act_val = ht_pos;
                else if (r_sat < ht_neg) act_val = ht_neg;
            end
            default: act_val = r_sat;
        endcase
    end

    // Datapath: capture, address stream, delayed accumulate, slot write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            act_q       <= '0;
            addr_q      <= '0;
            k_q         <= '0;
            n_q         <= '0;
            rd_vld_q    <= 1'b0;
            rd_k_q      <= '0;
            acc_q       <= '0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rd_vld_q    <= (state_q == ISSUE);
            rd_k_q      <= k_q;
            // Registered one cycle after entering OUT so the last slot has settled.
            out_valid_q <= (state_q == OUT) && !(out_valid_q && out_ready);
            if (rd_vld_q) acc_q <= acc_q + term;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q    <= in_vector;
                        act_q  <= act_mode;
                        addr_q <= ADDR_WIDTH'(weight_bank_sel) * BANK_STRIDE;
                        k_q    <= '0;
                        n_q    <= '0;
                    end
                end
                ISSUE: begin
                    addr_q <= addr_q + 1'b1;
                    k_q    <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
                end
                ACT: begin
                    out_vec_q[n_q*DATA_WIDTH +: DATA_WIDTH] <= act_val;
                    acc_q <= '0;
                    if (n_q != N_LAST) n_q <= n_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef TDNN_LAYER_SAT_STATS_EN
    logic [15:0] sat_q;

    // Sticky count of neurons that overflowed before activation.
    always_ff @(posedge clk) begin
        if (rst) sat_q <= '0;
        else if (state_q == ACT && sat_flag && sat_q != 16'hFFFF) sat_q <= sat_q + 1'b1;
    end

    assign sat_count = sat_q;
`endif

endmodule

// File: tb/tb_tdnn_layer_engine.sv
// Directed bench for tdnn_layer_engine at default parameters.
module tb_tdnn_layer_engine;

    localparam int DW    = 16;
    localparam int IN_D  = 18;
    localparam int OUT_D = 32;
    localparam int STR   = OUT_D * (IN_D + 1);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [DW*IN_D-1:0]    in_vector = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [1:0]            weight_bank_sel = '0;
    logic [1:0]            act_mode = '0;
    logic [15:0]           weight_addr;
    logic                  weight_rd_en;
    logic [15:0]           weight_data = '0;
    logic [DW*OUT_D-1:0]   out_vector;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic                  busy;
`ifdef TDNN_LAYER_SAT_STATS_EN
    logic [15:0]           sat_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [15:0] mem [0:4*STR-1];
    logic [DW*OUT_D-1:0] snap;

    tdnn_layer_engine dut (
        .clk             (clk),
        .rst             (rst),
        .in_vector       (in_vector),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .weight_bank_sel (weight_bank_sel),
        .act_mode        (act_mode),
        .weight_addr     (weight_addr),
        .weight_rd_en    (weight_rd_en),
        .weight_data     (weight_data),
        .out_vector      (out_vector),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy)
`ifdef TDNN_LAYER_SAT_STATS_EN
        ,
        .sat_count       (sat_count)
`endif
    );

    // Clock and synchronous weight memory with one cycle of read latency.
    always #5 clk = ~clk;
    always @(posedge clk) if (weight_rd_en) weight_data <= mem[weight_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int bank, input logic [15:0] w, input logic [15:0] b);
        for (int n = 0; n < OUT_D; n++)
            for (int k = 0; k <= IN_D; k++)
                mem[bank*STR + n*(IN_D+1) + k] = (k < IN_D) ? w : b;
    endtask

    task automatic set_x(input logic [15:0] x);
        for (int k = 0; k < IN_D; k++) in_vector[k*DW +: DW] = x;
    endtask

    task automatic start(input logic [15:0] x, input logic [1:0] bank, input logic [1:0] mode,
                         input logic [15:0] first_addr);
        @(negedge clk);
        set_x(x);
        weight_bank_sel = bank;
        act_mode        = mode;
        in_valid        = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        check("rd_en_first", 32'(weight_rd_en), 32'd1);
        check("first_addr", 32'(weight_addr), 32'(first_addr));
    endtask

    task automatic wait_out(input string tag, input int exp_lat, input bit toggle);
        int lat;
        bit done;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
            if (toggle && lat == 100) begin
                weight_bank_sel = 2'd0;
                act_mode        = 2'b11;
                in_vector       = '0;
            end
            if (out_valid === 1'b1) done = 1'b1;
        end
        check(tag, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_all(input string tag, input logic [15:0] exp);
        for (int n = 0; n < OUT_D; n++) check(tag, 32'(out_vector[n*DW +: DW]), 32'(exp));
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("consume_valid_low", 32'(out_valid), 32'd0);
        check("consume_in_ready", 32'(in_ready), 32'd1);
        check("consume_busy", 32'(busy), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [15:0] x, input logic [1:0] bank,
                       input logic [1:0] mode, input logic [15:0] exp);
        start(x, bank, mode, 16'(bank * STR));
        wait_out("latency", 673, 1'b0);
        check_all(tag, exp);
        consume();
    endtask

    initial begin
        fill(0, 16'h1000, 16'h0000);
        fill(1, 16'h2000, 16'h0000);
        fill(2, 16'h0000, 16'h0000);
        fill(3, 16'h0000, 16'h0000);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(weight_rd_en), 32'd0);
        check("rst_addr", 32'(weight_addr), 32'd0);
        check("rst_out_vector_zero", 32'(out_vector == '0), 32'd1);

        // Basic sum and latency: 18 * 0.125 * 0.125 = 0.28125.
        run("basic", 16'h1000, 2'd0, 2'b00, 16'h2400);

        // Activation modes.
        run("identity_neg", 16'hF000, 2'd0, 2'b00, 16'hDC00);
        run("relu_neg", 16'hF000, 2'd0, 2'b01, 16'h0000);
        run("leaky_neg", 16'hF000, 2'd0, 2'b10, 16'hFB80);
        run("htanh_pos", 16'h7FFF, 2'd0, 2'b11, 16'h4000);

        // Bias only.
        fill(0, 16'h1000, 16'h0800);
        run("bias_only", 16'h0000, 2'd0, 2'b00, 16'h0800);

        // Saturation.
        fill(0, 16'h7FFF, 16'h0000);
        run("saturate", 16'h7FFF, 2'd0, 2'b00, 16'h7FFF);
`ifdef TDNN_LAYER_SAT_STATS_EN
        check("sat_count_one", 32'(sat_count), 32'd32);
        run("saturate2", 16'h7FFF, 2'd0, 2'b00, 16'h7FFF);
        check("sat_count_two", 32'(sat_count), 32'd64);
`endif
        fill(0, 16'h1000, 16'h0000);

        // Bank select; inputs toggled mid-inference must not matter.
        start(16'h1000, 2'd1, 2'b00, 16'd608);
        wait_out("latency_bank1", 673, 1'b1);
        check_all("bank1", 16'h4800);
        consume();

        // Backpressure with a pending input held on in_valid.
        start(16'h1000, 2'd0, 2'b00, 16'd0);
        wait_out("latency_bp", 673, 1'b0);
        snap = out_vector;
        check_all("bp_result", 16'h2400);
        set_x(16'hF000);
        weight_bank_sel = 2'd1;
        act_mode        = 2'b00;
        in_valid        = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_stable", 32'(out_vector == snap), 32'd1);
        end
        consume();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accept_busy", 32'(busy), 32'd1);
        check("bp_accept_addr", 32'(weight_addr), 32'd608);
        wait_out("latency_after_bp", 673, 1'b0);
        check_all("bp_next", 16'hB800);
        consume();

        // Reset during neuron 10, then a fresh inference.
        start(16'h1000, 2'd0, 2'b00, 16'd0);
        repeat (215) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rd_en", 32'(weight_rd_en), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_vector_zero", 32'(out_vector == '0), 32'd1);
        run("after_reset", 16'h1000, 2'd0, 2'b00, 16'h2400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
